// File: rtl/riscv_m_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package riscv_m_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [6:0] M_FUNCT7 = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } muldiv_state_t;

  function automatic logic op_is_div(muldiv_op_t op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(muldiv_op_t op);
    return op[2] & op[1];
  endfunction

  // MULHSU is the only op whose operands differ in signedness.
  function automatic logic op_rs1_signed(muldiv_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_rs2_signed(muldiv_op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring step for divide.
module muldiv_step
  import riscv_m_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic              is_div_i,
  input  logic [2*XLEN:0]   acc_i,
  input  logic [XLEN-1:0]   operand_i,
  output logic [2*XLEN:0]   acc_o
);

  logic [XLEN:0] mul_upper;
  logic [XLEN:0] rem_shift;
  logic          qbit;

  // Multiply: acc = {carry/high, low}; divide: acc = {remainder[XLEN:0], quotient}.
  assign mul_upper = acc_i[2*XLEN:XLEN] + (acc_i[0] ? {1'b0, operand_i} : '0);
  assign rem_shift = acc_i[2*XLEN-1:XLEN-1];
  assign qbit      = rem_shift >= {1'b0, operand_i};

  always_comb begin
    acc_o = acc_i;
    if (is_div_i) begin
      acc_o = {(qbit ? (rem_shift - {1'b0, operand_i}) : rem_shift),
               acc_i[XLEN-2:0], qbit};
    end else begin
      acc_o = {1'b0, mul_upper, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: FSM, sign handling and result register.
// Define MULDIV_EARLY_OUT_EN to add zero-operand and small-dividend fast paths.
module muldiv_sequencer
  import riscv_m_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state_q, state_d;
  muldiv_op_t      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [2*XLEN:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] res_q, res_d;

  muldiv_op_t      op_in;
  logic            a_neg, b_neg, res_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            fast_hit;
  logic [XLEN-1:0] fast_res;
  logic [2*XLEN:0] step_acc;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quot, remv, fix_res;

  assign op_in   = muldiv_op_t'(funct3);
  assign a_neg   = op_rs1_signed(op_in) & rs1[XLEN-1];
  assign b_neg   = op_rs2_signed(op_in) & rs2[XLEN-1];
  assign a_abs   = a_neg ? -rs1 : rs1;
  assign b_abs   = b_neg ? -rs2 : rs2;
  assign res_neg = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);

  always_comb begin
    fast_hit = 1'b0;
    fast_res = '0;
    if (op_is_div(op_in) && (rs2 == '0)) begin
      fast_hit = 1'b1;
      fast_res = op_is_rem(op_in) ? rs1 : '1;
    end else if (((op_in == OP_DIV) || (op_in == OP_REM)) &&
                 (rs1 == INT_MIN) && (rs2 == '1)) begin
      fast_hit = 1'b1;
      fast_res = op_is_rem(op_in) ? '0 : INT_MIN;
    end
`ifdef MULDIV_EARLY_OUT_EN
    else if (!op_is_div(op_in) && ((rs1 == '0) || (rs2 == '0))) begin
      fast_hit = 1'b1;
      fast_res = '0;
    end else if (((op_in == OP_DIVU) || (op_in == OP_REMU)) && (rs1 < rs2)) begin
      fast_hit = 1'b1;
      fast_res = (op_in == OP_REMU) ? rs1 : '0;
    end
`endif
  end

  muldiv_step #(
    .XLEN (XLEN)
  ) u_step (
    .is_div_i  (op_is_div(op_q)),
    .acc_i     (acc_q),
    .operand_i (opb_q),
    .acc_o     (step_acc)
  );

  // Final sign correction and half/quotient/remainder selection.
  assign prod   = acc_q[2*XLEN-1:0];
  assign prod_s = neg_q ? -prod : prod;
  assign quot   = acc_q[XLEN-1:0];
  assign remv   = acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    case (op_q)
      OP_MUL:                       fix_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = neg_q ? -quot : quot;
      OP_REM, OP_REMU:              fix_res = neg_q ? -remv : remv;
      default:                      fix_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d  = op_in;
          neg_d = res_neg;
          opb_d = b_abs;
          acc_d = {{(XLEN+1){1'b0}}, a_abs};
          cnt_d = '0;
          if (fast_hit) begin
            res_d   = fast_res;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = step_acc;
          if (cnt_q == CNT_LAST) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          res_d   = fix_res;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
      opb_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign stall  = ((state_q != IDLE) && (state_q != DONE)) ||
                  ((state_q == IDLE) && start && !flush);
  assign done   = (state_q == DONE);
  assign result = res_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M cases plus random ops
// against a cycle-latency / arithmetic reference model.
module tb_muldiv_sequencer;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam int LAT_SLOW = 34;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_EARLY = 1;
`else
  localparam int LAT_EARLY = 34;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        flush = 1'b0;
  logic        busy, stall, done;
  logic [31:0] result;

  int checkCount = 0;
  int passCount  = 0;
  bit checkEn    = 1'b0;

  muldiv_sequencer dut (
    .clk    (clk),
    .reset  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Architectural result of an RV32M op, from plain integer arithmetic.
  function automatic logic [31:0] refResult(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == INT_MIN && b == 32'hFFFF_FFFF) return INT_MIN;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == INT_MIN && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int refLatency(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    bit fast;
    fast = (f[2] && b == 0) ||
           ((f == 3'd4 || f == 3'd6) && a == INT_MIN && b == 32'hFFFF_FFFF);
`ifdef MULDIV_EARLY_OUT_EN
    fast = fast || (!f[2] && (a == 0 || b == 0)) ||
           ((f == 3'd5 || f == 3'd7) && a < b);
`endif
    return fast ? 1 : LAT_SLOW;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  // Reference model: an accepted op runs for its latency, then one done cycle.
  logic [31:0] refR;
  int          refL;
  bit          mActive, mDone;
  int          mLeft;
  logic [31:0] mPend, mRes;

  assign refR = refResult(funct3, rs1, rs2);
  assign refL = refLatency(funct3, rs1, rs2);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mActive <= 1'b0; mDone <= 1'b0; mLeft <= 0; mPend <= '0; mRes <= '0;
    end else if (!mActive) begin
      if (start && !flush) begin
        mActive <= 1'b1;
        mPend   <= refR;
        mLeft   <= refL - 1;
        if (refL == 1) begin mDone <= 1'b1; mRes <= refR; end
      end
    end else if (mDone) begin
      mActive <= 1'b0; mDone <= 1'b0;
    end else if (flush) begin
      mActive <= 1'b0;
    end else begin
      mLeft <= mLeft - 1;
      if (mLeft == 1) begin mDone <= 1'b1; mRes <= mPend; end
    end
  end

  always @(negedge clk) begin
    if (checkEn && rst_n) begin
      checkOutput("cyc_busy", 32'(busy), 32'(mActive));
      checkOutput("cyc_stall", 32'(stall),
                  32'((mActive && !mDone) || (!mActive && start && !flush)));
      checkOutput("cyc_done", 32'(done), 32'(mDone));
      checkOutput("cyc_result", result, mRes);
    end
  end

  // Issue one op at posedge+1; optionally hold start and/or flush at cycle flushAt.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input bit hold, input int flushAt,
                               output int lat, output logic [31:0] res);
    bit seen;
    seen = 1'b0;
    lat  = -1;
    res  = '0;
    start = 1'b1; funct3 = f; rs1 = a; rs2 = b; flush = 1'b0;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    rs1 = $urandom;
    rs2 = $urandom;
    for (int n = 1; n <= 60; n++) begin
      if (n == flushAt) flush = 1'b1;
      @(negedge clk);
      if (done) begin seen = 1'b1; lat = n; res = result; break; end
      if (n == flushAt) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    if (flushAt < 1) checkOutput("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic runDirected(input string name, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] expRes, input int expLat);
    int lat;
    logic [31:0] res;
    applyStimulus(f, a, b, 1'b0, -1, lat, res);
    checkOutput({name, "_res"}, res, expRes);
    checkOutput({name, "_lat"}, 32'(lat), 32'(expLat));
    checkOutput({name, "_model"}, refResult(f, a, b), expRes);
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return INT_MIN;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    logic [31:0] res, prior;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkEn = 1'b1;
    @(posedge clk); #1;

    runDirected("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_SLOW);
    runDirected("mulh",   3'd1, INT_MIN,      INT_MIN,       32'h4000_0000, LAT_SLOW);
    runDirected("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_SLOW);
    runDirected("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, LAT_SLOW);
    runDirected("divu",   3'd5, 32'd100,      32'd7,         32'd14,        LAT_SLOW);
    runDirected("remu",   3'd7, 32'd100,      32'd7,         32'd2,         LAT_SLOW);
    runDirected("rem_neg",3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, LAT_SLOW);
    runDirected("div_neg",3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, LAT_SLOW);
    runDirected("div0",   3'd4, 32'd5,        32'd0,         32'hFFFF_FFFF, 1);
    runDirected("rem0",   3'd6, 32'd5,        32'd0,         32'd5,         1);
    runDirected("div_ovf",3'd4, INT_MIN,      32'hFFFF_FFFF, INT_MIN,       1);
    runDirected("rem_ovf",3'd6, INT_MIN,      32'hFFFF_FFFF, 32'd0,         1);
    runDirected("mul_zero",3'd0, 32'd0,       32'd5,         32'd0,         LAT_EARLY);
    runDirected("divu_small",3'd5, 32'd3,     32'd10,        32'd0,         LAT_EARLY);

    // Flush a DIVU mid-loop, then start a MUL the following cycle.
    prior = 32'd0;
    applyStimulus(3'd5, 32'd100, 32'd7, 1'b1, 10, lat, res);
    @(negedge clk);
    checkOutput("flush_busy", 32'(busy), 32'd0);
    checkOutput("flush_result", result, prior);
    @(posedge clk); #1;
    runDirected("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'd12, LAT_SLOW);

    // start and flush together in IDLE: nothing accepted.
    start = 1'b1; flush = 1'b1; funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    checkOutput("startflush_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a multiply.
    start = 1'b1; funct3 = 3'd0; rs1 = 32'h1234; rs2 = 32'h5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_done", 32'(done), 32'd0);
    checkOutput("arst_result", result, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("arst_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 150; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      int flushAt;
      f = 3'($urandom_range(0, 7));
      a = randOperand();
      b = randOperand();
      flushAt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 36)) : -1;
      applyStimulus(f, a, b, 1'($urandom_range(0, 1)), flushAt, lat, res);
      if (flushAt < 1) begin
        checkOutput("rand_lat", 32'(lat), 32'(refLatency(f, a, b)));
        checkOutput("rand_res", res, refResult(f, a, b));
      end
    end

    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative RV32M multiply/divide unit and its control FSM, sitting beside the main ALU in the execute stage. The decoder asserts start for funct7=0000001 R-type ops. The block stalls the pipeline while it runs a radix-2 shift-add or restoring-divide loop. It returns a single XLEN result with a one-cycle done pulse.

Parameters:
XLEN, 32, operand/result width
CNT_W, $clog2(XLEN), iteration counter width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (reset=0 resets)
start  in  1  request a new M-op; sampled only in IDLE
funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1  in  XLEN  operand A / dividend
rs2  in  XLEN  operand B / divisor
flush  in  1  abort current op (branch mispredict/trap)
busy  out  1  FSM not in IDLE
stall  out  1  (state!=IDLE && state!=DONE) || (state==IDLE && start && !flush); combinational
done  out  1  one-cycle pulse, result valid
result  out  XLEN  registered result; held until next accepted start

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, counter=0, all internal registers 0. Reset is asynchronous and overrides everything, including mid-op; no done is produced for an interrupted op.
- States: IDLE, CALC, FIX, DONE.
- IDLE + start (flush=0):
  - Latch funct3.
  - Capture |rs1| and |rs2| per signedness: MULH and DIV/REM treat both signed; MULHSU treats rs1 signed, rs2 unsigned; the rest are unsigned.
  - Record result sign.
  - Counter=0, go to CALC.
- Fast paths, decided in IDLE and taken IDLE→DONE, so done is asserted the next cycle:
  - Divisor zero: DIV/DIVU→all ones; REM/REMU→rs1.
  - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): DIV→0x80000000; REM→0.
- CALC: one iteration per cycle for XLEN cycles, counter 0..XLEN-1, then go to FIX.
  - Multiply: 2*XLEN product register.
  - Divide: XLEN quotient and XLEN+1 partial remainder.
- FIX: apply two's-complement negation per recorded sign and select the result.
  - Product: low half for MUL; high half for MULH/MULHSU/MULHU.
  - Division: quotient for DIV/DIVU; remainder for REM/REMU. Remainder takes the dividend's sign.
  - Write result, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
  - Start seen during DONE is ignored; the decoder holds start until done, so it is re-sampled in IDLE.
- Normal latency: start accepted at cycle 0 → done at cycle XLEN+2 (34).
- start while busy: ignored; operands are not re-sampled.
- flush: in any state except IDLE, return to IDLE next cycle with done=0 and result unchanged. In IDLE, flush masks start.
- flush and start in the same IDLE cycle: flush wins, nothing is accepted.
- Counter wrap: exits CALC at counter==XLEN-1; the counter never wraps inside an op.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: any multiply op with rs1==0 or rs2==0 takes the fast path IDLE→DONE with result=0 (latency 1). Unsigned divide with rs1<rs2 also takes the fast path: quotient 0, remainder rs1.
- Undefined: only the divide-by-zero and overflow fast paths exist. Every other op takes 34 cycles.

Decomposition:
- Package riscv_m_pkg holds:
  - muldiv_op_t enum over funct3 encodings.
  - muldiv_state_t enum {IDLE, CALC, FIX, DONE}.
  - Constant XLEN_DEFAULT=32.
  - Constant M_FUNCT7=7'b0000001.
- One sub-module is natural: muldiv_step, a combinational single iteration. Inputs: op class, accumulator, operand. Outputs: next accumulator/quotient bit. The sequencer owns the FSM, counter, sign handling and result register.

Test Plan:
- MUL, rs1=7, rs2=0xFFFFFFFD → done at cycle 34, result=0xFFFFFFEB; stall high cycles 0..33, low at 34.
- MULH, rs1=0x80000000, rs2=0x80000000 → result=0x40000000. MULHU, 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIVU 100/7 → 14 and REMU → 2, both at cycle 34. REM rs1=0xFFFFFFF9 (-7), rs2=2 → 0xFFFFFFFF.
- DIV 5/0 → 0xFFFFFFFF at cycle 1; REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0; both at cycle 1.
- DIVU 100/7 started, flush at cycle 10 → busy=0 at cycle 11, no done, result keeps its prior value. A new MUL 3×4 started at cycle 12 → done at cycle 46 with result=12.
- reset pulled low at cycle 20 of MUL → busy=0, done=0, result=0 immediately. With MULDIV_EARLY_OUT_EN: MUL 0×5 → result=0 at cycle 1.
